imem_loadable: RTL and testbench
================================

# imem_loadable

Parametrised, loadable instruction memory for the MIPS_Processor fetch stage. It replaces a fixed combinational program ROM with synchronous storage that is filled at run time through a streaming load port. Instructions are then served to the fetch unit through a one-cycle-latency request/valid interface. Fetches beyond the loaded program length return a NOP word and are flagged.

## Interface
Parameters:
- `ADDR_W`, 8: fetch address width; one address per instruction word.
- `DATA_W`, 16: instruction word width.
- `DEPTH`, 256: number of words; must satisfy 2 ≤ DEPTH ≤ 2^ADDR_W.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `load_start`  in  1: pulse; begins a new program load at address 0.
- `load_valid`  in  1: `load_data` is valid this cycle.
- `load_data`  in  DATA_W: program word.
- `load_last`  in  1: qualifies the final beat of a load.
- `load_ready`  out  1: load beat is accepted when `load_valid && load_ready`.
- `load_done`  out  1: one-cycle pulse when a load completes.
- `prog_len`  out  ADDR_W+1: number of words loaded.
- `fetch_req`  in  1: fetch request.
- `fetch_addr`  in  ADDR_W: word address.
- `fetch_ready`  out  1: request is accepted when `fetch_req && fetch_ready`.
- `instr_valid`  out  1: `instr_data` is valid this cycle.
- `instr_data`  out  DATA_W: fetched word.
- `fetch_err`  out  1: out-of-program fetch; qualified by `instr_valid`.
- `parity_err`  out  1: stored-word parity mismatch; qualified by `instr_valid`.

## Operation
- State machine with three states: EMPTY, LOAD, RUN.
  - Reset enters EMPTY.
  - `load_start` in any state goes to LOAD and clears `wr_ptr` to 0.
  - LOAD goes to RUN on an accepted beat with `load_last`, or on an accepted beat at `wr_ptr == DEPTH-1` (full).
- `load_ready` = (state == LOAD) && !`load_start`.
  - `load_start` together with `load_valid` in the same cycle: restart wins and the beat is not written.
- Each accepted load beat writes `mem[wr_ptr]` and increments `wr_ptr`.
  - `prog_len` updates to `wr_ptr+1` on the terminating beat only.
  - Entering LOAD sets `prog_len` to 0.
- `fetch_ready` = (state == RUN) && !`load_start`. Requests while not ready are dropped; the requester retries.
- For an accepted fetch:
  - If `fetch_addr < prog_len`: `instr_data = mem[fetch_addr]`, `fetch_err = 0`.
  - Otherwise: `instr_data = 0` (NOP), `fetch_err = 1`.
- Comparisons are unsigned and done at width ADDR_W+1, so that `prog_len == DEPTH == 2^ADDR_W` is handled without wrap.
- Memory contents are not cleared by reset or by a new load. Unreached words become unreachable through `prog_len`.

## Timing
- Reset values: state = EMPTY, `wr_ptr` = 0, `prog_len` = 0, and `load_ready`, `load_done`, `fetch_ready`, `instr_valid`, `instr_data`, `fetch_err`, `parity_err` all 0.
- Fetch latency is 1 cycle: a request accepted at edge N gives `instr_valid` high for exactly the cycle after edge N.
- Fetches are fully pipelined, one per cycle. There is no output backpressure.
- `load_done` pulses high on the cycle after the terminating beat, coincident with state == RUN.
- First fetch can be accepted in that same cycle.
- Load into RUN while fetches are in flight: the in-flight fetch completes using the old `prog_len`.
- `rst` asserted mid-load or mid-fetch: all outputs return to reset values immediately and any pending `instr_valid` is cancelled.
- A write and a fetch to the same address never coincide, because writes occur only in LOAD.

## Configuration
- Controlled by `IMEM_PARITY_EN`.
- When defined:
  - Each word stores one extra even-parity bit computed on write.
  - On fetch, parity is recomputed over the read word.
  - A mismatch sets `parity_err` together with `instr_valid`; the data is still returned.
  - Out-of-program fetches report `parity_err = 0`.
- When undefined: no parity storage, and `parity_err` is tied to 0.

## Structure
- Shared package `imem_pkg`:
  - State encoding: EMPTY = 2'd0, LOAD = 2'd1, RUN = 2'd2.
  - NOP word constant (all zeros).
  - Default width and depth constants.
- Sub-module `imem_array`:
  - Single write port and single synchronous read port.
  - DATA_W (+1 when parity is enabled) by DEPTH.
  - Contains no control logic.
- Top level holds the FSM, pointers, range check and parity logic.

## Test plan
- Reset with `fetch_req = 1`: `fetch_ready = 0`, `instr_valid` never asserts, `prog_len = 0`.
- Load 9 words 485A, 4A14, 4DF6, 4F96, 0880, 4E02, 6180, 6800, 8820 with `load_last` on the 9th beat: `load_done` pulses once and `prog_len = 9`. Then back-to-back fetches of addresses 0..8 return the same words at 1-cycle latency, with `fetch_err = 0`.
- With `prog_len = 9`, fetch address 9 and address 0xFF: `instr_data = 0000` and `fetch_err = 1`.
- Load of DEPTH = 256 words with no `load_last`: automatic transition to RUN, `prog_len = 256`, and a fetch of 0xFF returns the last word.
- `load_start` on the 4th beat of a load, then 2 words A5A5, 1234 with `load_last`: `prog_len = 2`, a fetch of address 0 returns A5A5, and a fetch of address 2 gives `fetch_err = 1`.
- `rst` pulsed mid-load, and separately with `IMEM_PARITY_EN` and a forced bit flip in `imem_array`:
  - Reset case: state returns to EMPTY and `prog_len = 0`.
  - Bit-flip case: the fetch of the corrupted word asserts `parity_err = 1`.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: state encoding,
// NOP word, default geometry and the even-parity helper.
package imem_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DATA_W = 16;
    localparam int IMEM_DEPTH  = 256;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // Sliced to DATA_W at the point of use; widths up to 64 bits are supported.
    localparam logic [63:0] NOP_WORD = 64'd0;

    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Storage for the instruction memory: one write port, one registered read port,
// no reset on contents and no control logic.
module imem_array #(
    parameter int ADDR_W = 8,
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Write port and synchronous read port share the clock.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: streaming load port, 1-cycle fetch port with
// out-of-program detection. Optional per-word parity when IMEM_PARITY_EN is defined.
module imem_loadable
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   prog_len,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic              fetch_err,
    output logic              parity_err
);

`ifdef IMEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int MEM_W = DATA_W + PAR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    logic [1:0]        state_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W:0]   prog_len_r;
    logic              load_done_r;
    logic              instr_valid_r;
    logic              fetch_err_r;

    logic              load_accept_s;
    logic              load_term_s;
    logic              at_full_s;
    logic              fetch_accept_s;
    logic              in_range_s;
    logic [MEM_W-1:0]  wr_word_s;
    logic [MEM_W-1:0]  rd_word_s;

    assign load_ready     = (state_r == ST_LOAD) && !load_start;
    assign fetch_ready    = (state_r == ST_RUN) && !load_start;
    assign load_accept_s  = load_valid && load_ready;
    assign at_full_s      = ({1'b0, wr_ptr_r} == LAST_IDX);
    assign load_term_s    = load_accept_s && (load_last || at_full_s);
    assign fetch_accept_s = fetch_req && fetch_ready;
    // One extra bit so a full 2^ADDR_W program does not wrap to zero.
    assign in_range_s     = ({1'b0, fetch_addr} < prog_len_r);

    // Load FSM, write pointer and program length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            wr_ptr_r    <= {ADDR_W{1'b0}};
            prog_len_r  <= {(ADDR_W+1){1'b0}};
            load_done_r <= 1'b0;
        end else begin
            load_done_r <= load_term_s;
            if (load_start) begin
                state_r    <= ST_LOAD;
                wr_ptr_r   <= {ADDR_W{1'b0}};
                prog_len_r <= {(ADDR_W+1){1'b0}};
            end else begin
                if (load_accept_s) begin
                    wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
                end
                if (load_term_s) begin
                    state_r    <= ST_RUN;
                    prog_len_r <= {1'b0, wr_ptr_r} + (ADDR_W+1)'(1);
                end
            end
        end
    end

    // Fetch response qualifiers, one cycle behind the accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_valid_r <= 1'b0;
            fetch_err_r   <= 1'b0;
        end else begin
            instr_valid_r <= fetch_accept_s;
            fetch_err_r   <= fetch_accept_s && !in_range_s;
        end
    end

`ifdef IMEM_PARITY_EN
    assign wr_word_s  = {even_parity(64'(load_data)), load_data};
    assign parity_err = instr_valid_r && !fetch_err_r &&
                        (even_parity(64'(rd_word_s[DATA_W-1:0])) != rd_word_s[DATA_W]);
`else
    assign wr_word_s  = load_data;
    assign parity_err = 1'b0;
`endif

    imem_array #(
        .ADDR_W (ADDR_W),
        .WIDTH  (MEM_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (load_accept_s),
        .waddr (wr_ptr_r),
        .wdata (wr_word_s),
        .re    (fetch_accept_s && in_range_s),
        .raddr (fetch_addr),
        .rdata (rd_word_s)
    );

    // Read register holds stale data on misses and idle cycles, so mask it here.
    assign instr_data  = (instr_valid_r && !fetch_err_r) ? rd_word_s[DATA_W-1:0]
                                                         : NOP_WORD[DATA_W-1:0];
    assign instr_valid = instr_valid_r;
    assign fetch_err   = fetch_err_r;
    assign load_done   = load_done_r;
    assign prog_len    = prog_len_r;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed self-checking bench for imem_loadable (default geometry).
// Parity corruption case runs only when IMEM_PARITY_EN is defined.
module tb_imem_loadable;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_done;
    logic [8:0]  prog_len;
    logic        fetch_req;
    logic [7:0]  fetch_addr;
    logic        fetch_ready;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic        fetch_err;
    logic        parity_err;

    int n_cmp;
    int n_err;

    logic [15:0] prog9 [9];

    imem_loadable u_dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .prog_len    (prog_len),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .fetch_err   (fetch_err),
        .parity_err  (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        #1;
        check_eq("load_ready_after_start", 32'(load_ready), 32'd1);
        check_eq("prog_len_after_start", 32'(prog_len), 32'd0);
    endtask

    task automatic send_beat(input logic [15:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch_one(input string tag, input logic [7:0] a, input logic [15:0] exp_d,
                             input logic exp_fe, input logic exp_pe);
        fetch_req  = 1'b1;
        fetch_addr = a;
        @(negedge clk);
        fetch_req  = 1'b0;
        check_eq({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(instr_data), 32'(exp_d));
        check_eq({tag, "_ferr"}, 32'(fetch_err), 32'(exp_fe));
        check_eq({tag, "_perr"}, 32'(parity_err), 32'(exp_pe));
        @(negedge clk);
        check_eq({tag, "_valid_drop"}, 32'(instr_valid), 32'd0);
    endtask

    task automatic load_prog9();
        start_load();
        for (int i = 0; i < 9; i++) begin
            send_beat(prog9[i], (i == 8) ? 1'b1 : 1'b0);
            if (i == 4) begin
                check_eq("load_done_mid", 32'(load_done), 32'd0);
            end
        end
        check_eq("load_done_p9", 32'(load_done), 32'd1);
        check_eq("prog_len_p9", 32'(prog_len), 32'd9);
        check_eq("fetch_ready_p9", 32'(fetch_ready), 32'd1);
        @(negedge clk);
        check_eq("load_done_once_p9", 32'(load_done), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        prog9[0] = 16'h485A; prog9[1] = 16'h4A14; prog9[2] = 16'h4DF6;
        prog9[3] = 16'h4F96; prog9[4] = 16'h0880; prog9[5] = 16'h4E02;
        prog9[6] = 16'h6180; prog9[7] = 16'h6800; prog9[8] = 16'h8820;

        rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = 16'h0000;
        load_last = 1'b0; fetch_req = 1'b1; fetch_addr = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_prog_len", 32'(prog_len), 32'd0);
        check_eq("rst_load_ready", 32'(load_ready), 32'd0);
        check_eq("rst_instr_data", 32'(instr_data), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("empty_instr_valid", 32'(instr_valid), 32'd0);
        end
        fetch_req = 1'b0;

        // Nine-word program, then back-to-back fetches of 0..8.
        load_prog9();
        fetch_req  = 1'b1;
        fetch_addr = 8'h00;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check_eq("b2b_valid", 32'(instr_valid), 32'd1);
            check_eq("b2b_data", 32'(instr_data), 32'(prog9[i]));
            check_eq("b2b_ferr", 32'(fetch_err), 32'd0);
            if (i < 8) fetch_addr = 8'(i + 1);
            else       fetch_req  = 1'b0;
        end
        @(negedge clk);
        check_eq("b2b_valid_end", 32'(instr_valid), 32'd0);

        fetch_one("oor_9", 8'h09, 16'h0000, 1'b1, 1'b0);
        fetch_one("oor_ff", 8'hFF, 16'h0000, 1'b1, 1'b0);

        // Reset while a fetch response is pending.
        fetch_req  = 1'b1;
        fetch_addr = 8'h01;
        @(posedge clk);
        #2;
        fetch_req = 1'b0;
        check_eq("pre_rst_valid", 32'(instr_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_fetch_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_fetch_data", 32'(instr_data), 32'd0);
        check_eq("rst_fetch_state", 32'(u_dut.state_r), 32'd0);
        check_eq("rst_fetch_plen", 32'(prog_len), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a load.
        start_load();
        for (int i = 0; i < 3; i++) send_beat(prog9[i], 1'b0);
        rst = 1'b1;
        #1;
        check_eq("rst_load_state", 32'(u_dut.state_r), 32'd0);
        check_eq("rst_load_plen", 32'(prog_len), 32'd0);
        check_eq("rst_load_ready", 32'(load_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        check_eq("rst_load_fready", 32'(fetch_ready), 32'd0);
        @(negedge clk);
        check_eq("rst_load_novalid", 32'(instr_valid), 32'd0);

        load_prog9();
        fetch_one("reload_a3", 8'h03, 16'h4F96, 1'b0, 1'b0);
`ifdef IMEM_PARITY_EN
        u_dut.u_array.mem_r[4][0] = ~u_dut.u_array.mem_r[4][0];
        fetch_one("flip_a4", 8'h04, 16'h0881, 1'b0, 1'b1);
        fetch_one("clean_a5", 8'h05, 16'h4E02, 1'b0, 1'b0);
`endif

        // Full-depth load with no terminating flag.
        start_load();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            send_beat({b, ~b}, 1'b0);
        end
        check_eq("full_load_done", 32'(load_done), 32'd1);
        check_eq("full_prog_len", 32'(prog_len), 32'd256);
        check_eq("full_state_run", 32'(u_dut.state_r), 32'd2);
        fetch_one("full_ff", 8'hFF, 16'hFF00, 1'b0, 1'b0);
        fetch_one("full_00", 8'h00, 16'h00FF, 1'b0, 1'b0);
        fetch_one("full_80", 8'h80, 16'h807F, 1'b0, 1'b0);

        // Restart on the fourth beat; the colliding beat must be dropped.
        start_load();
        for (int i = 0; i < 3; i++) send_beat(16'h1111, 1'b0);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'hDEAD;
        #1;
        check_eq("restart_ready", 32'(load_ready), 32'd0);
        @(negedge clk);
        load_start = 1'b0;
        load_valid = 1'b0;
        check_eq("restart_plen", 32'(prog_len), 32'd0);
        send_beat(16'hA5A5, 1'b0);
        send_beat(16'h1234, 1'b1);
        check_eq("restart_done", 32'(load_done), 32'd1);
        check_eq("restart_plen2", 32'(prog_len), 32'd2);
        fetch_one("restart_a0", 8'h00, 16'hA5A5, 1'b0, 1'b0);
        fetch_one("restart_a1", 8'h01, 16'h1234, 1'b0, 1'b0);
        fetch_one("restart_a2", 8'h02, 16'h0000, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
